// File: rtl/branch_predict_ctrl_if.sv
// Pipeline-facing signal bundle for branch_predict_ctrl: s1 lookup, s2 resolve, redirect and perf outputs.
// master = pipeline side, slave = branch_predict_ctrl.
interface branch_predict_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic              stall;
    logic [31:0]       pc_s1;
    logic              is_branch_s1;
    logic              is_jal_s1;
    logic              pred_taken_s1;
    logic [31:0]       instruction_s2;
    logic [31:0]       pc_s2;
    logic              pred_taken_s2;
    logic              breq;
    logic              brlt;
    logic [2:0]        pc_sel;
    logic              flush_s1;
    logic [CNT_W-1:0]  branch_count;
    logic [CNT_W-1:0]  mispredict_count;

    modport master (
        output stall, pc_s1, is_branch_s1, is_jal_s1, instruction_s2, pc_s2,
               pred_taken_s2, breq, brlt,
        input  pred_taken_s1, pc_sel, flush_s1, branch_count, mispredict_count
    );

    modport slave (
        input  stall, pc_s1, is_branch_s1, is_jal_s1, instruction_s2, pc_s2,
               pred_taken_s2, breq, brlt,
        output pred_taken_s1, pc_sel, flush_s1, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predict_ctrl.sv
// PC-select control with a direct-mapped BHT of saturating counters (s1 predict, s2 resolve).
// Define BRANCH_PERF_EN to build the branch / mispredict performance counters.
module branch_predict_ctrl #(
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned CTR_BITS    = 2,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_predict_ctrl_if.slave  bus
);
    localparam int unsigned         IDX_W   = $clog2(BHT_ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_MAX >> 1;
    localparam logic [4:0]          OP_BRANCH = 5'b11000;
    localparam logic [4:0]          OP_JALR   = 5'b11001;

    typedef enum logic [2:0] {
        PC_PLUS4   = 3'd0,
        PC_ALU     = 3'd1,
        PC_S1_TGT  = 3'd2,
        PC_RESET   = 3'd3,
        PC_RECOVER = 3'd4
    } pc_sel_e;

    logic [CTR_BITS-1:0] r_bht [BHT_ENTRIES];

    logic [IDX_W-1:0]    w_idx_s1;
    logic [IDX_W-1:0]    w_idx_s2;
    logic [CTR_BITS-1:0] w_ctr_s2;
    logic [4:0]          w_opcode;
    logic [2:0]          w_func3;
    logic                w_is_br;
    logic                w_is_jalr;
    logic                w_f3_ok;
    logic                w_taken;
    logic                w_br_valid;
    logic                w_mispredict;
    logic                w_pred_s1;
    logic                w_upd;
    pc_sel_e             w_pc_sel;
    logic                w_flush;
    logic                w_unused;

    assign w_idx_s1   = bus.pc_s1[IDX_W+1:2];
    assign w_idx_s2   = bus.pc_s2[IDX_W+1:2];
    assign w_ctr_s2   = r_bht[w_idx_s2];
    assign w_opcode   = bus.instruction_s2[6:2];
    assign w_func3    = bus.instruction_s2[14:12];
    assign w_is_br    = (w_opcode == OP_BRANCH);
    assign w_is_jalr  = (w_opcode == OP_JALR);

    always_comb begin
        w_taken = 1'b0;
        w_f3_ok = 1'b1;
        case (w_func3)
            3'b000:          w_taken = bus.breq;
            3'b001:          w_taken = ~bus.breq;
            3'b100, 3'b110:  w_taken = bus.brlt;
            3'b101, 3'b111:  w_taken = ~bus.brlt;
            default:         w_f3_ok = 1'b0;
        endcase
    end

    assign w_br_valid   = w_is_br & w_f3_ok;
    // Invalid func3 resolves not-taken, so a predicted-taken one still recovers.
    assign w_mispredict = w_is_br & (w_taken != bus.pred_taken_s2);
    assign w_pred_s1    = ~rst & bus.is_branch_s1 & r_bht[w_idx_s1][CTR_BITS-1];
    assign w_upd        = ~bus.stall & w_br_valid;

    always_comb begin
        w_pc_sel = PC_PLUS4;
        w_flush  = 1'b0;
        if (rst) begin
            w_pc_sel = PC_RESET;
        end else if (w_is_jalr) begin
            w_pc_sel = PC_ALU;
            w_flush  = 1'b1;
        end else if (w_mispredict) begin
            w_pc_sel = w_taken ? PC_ALU : PC_RECOVER;
            w_flush  = 1'b1;
        end else if (bus.is_jal_s1 | w_pred_s1) begin
            w_pc_sel = PC_S1_TGT;
        end
    end

    assign bus.pred_taken_s1 = w_pred_s1;
    assign bus.pc_sel        = w_pc_sel;
    assign bus.flush_s1      = w_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= CTR_WNT;
            end
        end else if (w_upd) begin
            if (w_taken && (w_ctr_s2 != CTR_MAX)) begin
                r_bht[w_idx_s2] <= w_ctr_s2 + CTR_BITS'(1);
            end else if (!w_taken && (w_ctr_s2 != '0)) begin
                r_bht[w_idx_s2] <= w_ctr_s2 - CTR_BITS'(1);
            end
        end
    end

`ifdef BRANCH_PERF_EN
    logic [CNT_W-1:0] r_branch_count;
    logic [CNT_W-1:0] r_mispredict_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (w_upd) begin
            r_branch_count <= r_branch_count + CNT_W'(1);
            if (w_mispredict) begin
                r_mispredict_count <= r_mispredict_count + CNT_W'(1);
            end
        end
    end

    assign bus.branch_count     = r_branch_count;
    assign bus.mispredict_count = r_mispredict_count;
`else
    assign bus.branch_count     = CNT_W'(0);
    assign bus.mispredict_count = CNT_W'(0);
`endif

    // Only the index bits of the PCs and the opcode/func3 fields are consulted.
    assign w_unused = ^{bus.pc_s1[31:IDX_W+2], bus.pc_s1[1:0],
                        bus.pc_s2[31:IDX_W+2], bus.pc_s2[1:0],
                        bus.instruction_s2[31:15], bus.instruction_s2[11:7],
                        bus.instruction_s2[1:0]};
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: directed plan with literal expectations, then random traffic vs a model.
module tb_branch_predict_ctrl;
    localparam int unsigned ENTRIES = 64;
    localparam int unsigned CB      = 2;
    localparam int unsigned CW      = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predict_ctrl_if #(.CNT_W(CW)) bus ();

    branch_predict_ctrl #(
        .BHT_ENTRIES(ENTRIES),
        .CTR_BITS(CB),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Model state: plain integer counters per entry and plain event tallies.
    int unsigned     m_ctr [ENTRIES];
    logic [CW-1:0]   m_br;
    logic [CW-1:0]   m_mis;
    int              n_pass  = 0;
    int              n_total = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [CW-1:0] perf(input logic [CW-1:0] v);
`ifdef BRANCH_PERF_EN
        return v;
`else
        return '0;
`endif
    endfunction

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (int'(pc) / 4) % ENTRIES;
    endfunction

    function automatic bit f3_valid(input logic [2:0] f3);
        return !(f3 == 3'd2 || f3 == 3'd3);
    endfunction

    function automatic bit outcome(input logic [2:0] f3, input bit eq, input bit lt);
        case (f3)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] f3);
        logic [16:0] hi;
        logic [4:0]  rd;
        hi = 17'($urandom);
        rd = 5'($urandom);
        return {hi, f3, rd, op, 2'b11};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_ctr[i] = (1 << (CB - 1)) - 1;
        m_br  = '0;
        m_mis = '0;
    endtask

    // Per-cycle comparison of every DUT output against the model.
    task automatic model_check();
        logic [4:0] op;
        logic [2:0] f3;
        bit is_br, is_jalr, taken, mis, pred1;
        int unsigned sel;
        bit flush;
        op      = bus.instruction_s2[6:2];
        f3      = bus.instruction_s2[14:12];
        is_br   = (op == 5'b11000);
        is_jalr = (op == 5'b11001);
        taken   = is_br && outcome(f3, bus.breq, bus.brlt);
        mis     = is_br && (taken != bus.pred_taken_s2);
        pred1   = !rst && bus.is_branch_s1 && (m_ctr[idx_of(bus.pc_s1)] >= (1 << (CB - 1)));
        flush   = 1'b0;
        if (rst)                               sel = 3;
        else if (is_jalr)                      begin sel = 1; flush = 1'b1; end
        else if (mis)                          begin sel = taken ? 1 : 4; flush = 1'b1; end
        else if (bus.is_jal_s1 || pred1)       sel = 2;
        else                                   sel = 0;
        chk("pred_taken_s1", bus.pred_taken_s1, pred1);
        chk("pc_sel", bus.pc_sel, sel);
        chk("flush_s1", bus.flush_s1, flush);
        chk("branch_count", bus.branch_count, perf(m_br));
        chk("mispredict_count", bus.mispredict_count, perf(m_mis));
    endtask

    task automatic model_update();
        logic [4:0] op;
        logic [2:0] f3;
        bit taken;
        int unsigned i;
        op = bus.instruction_s2[6:2];
        f3 = bus.instruction_s2[14:12];
        if (rst) begin
            model_reset();
        end else if (!bus.stall && op == 5'b11000 && f3_valid(f3)) begin
            taken = outcome(f3, bus.breq, bus.brlt);
            i = idx_of(bus.pc_s2);
            if (taken) m_ctr[i] = (m_ctr[i] == (1 << CB) - 1) ? m_ctr[i] : m_ctr[i] + 1;
            else       m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            m_br = m_br + 1;
            if (taken != bus.pred_taken_s2) m_mis = m_mis + 1;
        end
    endtask

    task automatic eval();
        @(negedge clk);
        model_check();
    endtask

    task automatic adv();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall          = 1'b0;
        bus.pc_s1          = '0;
        bus.is_branch_s1   = 1'b0;
        bus.is_jal_s1      = 1'b0;
        bus.instruction_s2 = 32'h0000_0013;
        bus.pc_s2          = '0;
        bus.pred_taken_s2  = 1'b0;
        bus.breq           = 1'b0;
        bus.brlt           = 1'b0;
    endtask

    task automatic s1_lookup(input logic [31:0] pc);
        bus.pc_s1 = pc;
        bus.is_branch_s1 = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        @(posedge clk);
        #1;

        // Reset held two cycles with s1 and s2 both requesting redirects.
        for (int k = 0; k < 2; k++) begin
            s1_lookup(32'h10);
            bus.is_jal_s1 = 1'b1;
            bus.instruction_s2 = mk(5'b11001, 3'd0);
            eval();
            chk("rst_pc_sel", bus.pc_sel, 3);
            chk("rst_flush", bus.flush_s1, 0);
            chk("rst_pred", bus.pred_taken_s1, 0);
            chk("rst_bcount", bus.branch_count, 0);
            chk("rst_mcount", bus.mispredict_count, 0);
            adv();
        end
        rst = 1'b0;
        idle();

        s1_lookup(32'h10);
        eval();
        chk("post_rst_pred", bus.pred_taken_s1, 0);
        adv();

        // Train idx 4 with two mispredicted taken BEQs.
        for (int k = 0; k < 2; k++) begin
            s1_lookup(32'h10);
            bus.instruction_s2 = mk(5'b11000, 3'd0);
            bus.pc_s2 = 32'h10;
            bus.breq = 1'b1;
            eval();
            chk("train_pc_sel", bus.pc_sel, 1);
            chk("train_flush", bus.flush_s1, 1);
            chk("train_pred", bus.pred_taken_s1, k);
            adv();
        end

        bus.is_branch_s1 = 1'b0;
        bus.pred_taken_s2 = 1'b1;
        eval();
        chk("correct_pc_sel", bus.pc_sel, 0);
        chk("correct_flush", bus.flush_s1, 0);
        adv();

        // Counter now saturated at 3: BNE not taken but predicted taken.
        idle();
        s1_lookup(32'h10);
        bus.instruction_s2 = mk(5'b11000, 3'd1);
        bus.pc_s2 = 32'h10;
        bus.breq = 1'b1;
        bus.pred_taken_s2 = 1'b1;
        eval();
        chk("recover_pc_sel", bus.pc_sel, 4);
        chk("recover_flush", bus.flush_s1, 1);
        chk("recover_pred", bus.pred_taken_s1, 1);
        chk("bcount_3", bus.branch_count, perf(3));
        chk("mcount_2", bus.mispredict_count, perf(2));
        adv();

        // 3 -> 2: still predicts taken, seen through an aliased PC.
        bus.pred_taken_s2 = 1'b0;
        s1_lookup(32'h110);
        eval();
        chk("alias_pred", bus.pred_taken_s1, 1);
        chk("alias_pc_sel", bus.pc_sel, 2);
        chk("mcount_3", bus.mispredict_count, perf(3));
        adv();

        // 2 -> 1; JALR beats the s1 JAL.
        idle();
        s1_lookup(32'h10);
        bus.is_jal_s1 = 1'b1;
        bus.instruction_s2 = mk(5'b11001, 3'd0);
        bus.pc_s2 = 32'h10;
        eval();
        chk("jalr_pc_sel", bus.pc_sel, 1);
        chk("jalr_flush", bus.flush_s1, 1);
        chk("jalr_pred", bus.pred_taken_s1, 0);
        adv();

        idle();
        bus.stall = 1'b1;
        s1_lookup(32'h10);
        bus.instruction_s2 = mk(5'b11000, 3'd4);
        bus.pc_s2 = 32'h10;
        bus.brlt = 1'b1;
        eval();
        chk("stall_pc_sel", bus.pc_sel, 1);
        chk("stall_flush", bus.flush_s1, 1);
        adv();

        // Stalled update dropped: counter still 1; now same-cycle lookup/update 1 -> 2.
        bus.stall = 1'b0;
        bus.pred_taken_s2 = 1'b1;
        eval();
        chk("hazard_pred_old", bus.pred_taken_s1, 0);
        chk("hazard_pc_sel", bus.pc_sel, 0);
        chk("stall_bcount", bus.branch_count, perf(5));
        adv();

        idle();
        s1_lookup(32'h10);
        eval();
        chk("hazard_pred_new", bus.pred_taken_s1, 1);
        chk("bcount_6", bus.branch_count, perf(6));
        adv();

        idle();
        bus.instruction_s2 = mk(5'b11000, 3'd2);
        bus.pc_s2 = 32'h10;
        bus.pred_taken_s2 = 1'b1;
        eval();
        chk("inv_pc_sel", bus.pc_sel, 4);
        chk("inv_flush", bus.flush_s1, 1);
        adv();

        idle();
        s1_lookup(32'h10);
        eval();
        chk("inv_pred_kept", bus.pred_taken_s1, 1);
        chk("inv_bcount", bus.branch_count, perf(6));
        chk("inv_mcount", bus.mispredict_count, perf(3));
        adv();

        // Random traffic over a small, heavily aliased PC pool.
        for (int n = 0; n < 3000; n++) begin
            int unsigned kind;
            logic [4:0] op;
            rst = ($urandom_range(0, 99) == 0);
            bus.stall = ($urandom_range(0, 4) == 0);
            bus.pc_s1 = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            bus.pc_s2 = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            bus.is_branch_s1 = $urandom_range(0, 1);
            bus.is_jal_s1 = ($urandom_range(0, 5) == 0);
            kind = $urandom_range(0, 7);
            if (kind < 6)       op = 5'b11000;
            else if (kind == 6) op = 5'b11001;
            else                op = 5'($urandom);
            bus.instruction_s2 = mk(op, 3'($urandom));
            bus.pred_taken_s2 = $urandom_range(0, 1);
            bus.breq = $urandom_range(0, 1);
            bus.brlt = $urandom_range(0, 1);
            eval();
            adv();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Parametrised successor to the stage-3 PC-select control in the 3-stage RV32I core.
- Adds a direct-mapped branch history table (BHT) of saturating counters for fetch-stage (s1) prediction.
- Resolves branches and JALR in s2, generates pc_sel and s1 flush, and optionally counts branches and mispredicts.

Parameters:
BHT_ENTRIES, 64, number of counters; power of 2, ≥2; IDX_W = log2(BHT_ENTRIES)
CTR_BITS, 2, saturating counter width (1..4)
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst  in  1  reset
stall  in  1  pipeline hold; gates all state updates
pc_s1  in  32  fetch PC for lookup
is_branch_s1  in  1  s1 predecode: conditional branch
is_jal_s1  in  1  s1 predecode: JAL
pred_taken_s1  out  1  prediction for the s1 instruction
instruction_s2  in  32  instruction in execute stage
pc_s2  in  32  PC of instruction_s2
pred_taken_s2  in  1  prediction carried from s1 with instruction_s2
breq  in  1  comparator equal
brlt  in  1  comparator less-than, signedness already chosen by func3
pc_sel  out  3  0 = pc+4; 1 = ALU target; 2 = s1 target; 3 = reset vector; 4 = pc_s2+4 recovery
flush_s1  out  1  kill the instruction currently in s1
branch_count  out  CNT_W  resolved conditional branches
mispredict_count  out  CNT_W  mispredicted conditional branches

Behaviour:
- Reset is synchronous and active-high (rst).
  - On rst: every BHT counter is set to weakly-not-taken, i.e. MSB=0 with all lower bits 1 (2'b01 at default width).
  - Both perf counters are cleared.
  - While rst is high: pc_sel=3, flush_s1=0, pred_taken_s1=0.
- Lookup, combinational:
  - idx_s1 = pc_s1[IDX_W+1:2].
  - pred_taken_s1 = is_branch_s1 & bht[idx_s1][CTR_BITS-1].
- Decode s2:
  - opcode = instruction_s2[6:2]: BRANCH=11000, JALR=11001.
  - func3 = instruction_s2[14:12].
- Actual branch outcome (taken_s2) by func3:
  - 000 breq; 001 !breq; 100 brlt; 101 !brlt; 110 brlt; 111 !brlt.
  - func3 010/011 are invalid: not taken, no BHT update, not counted.
- Conditional branch s2 is valid when opcode==BRANCH and func3 is valid.
- Mispredict = (opcode==BRANCH) & (taken_s2 != pred_taken_s2).
- pc_sel priority, combinational, evaluated every cycle including stall:
  1. rst → 3
  2. JALR in s2 → 1, flush_s1=1
  3. mispredict and taken_s2 → 1, flush_s1=1
  4. mispredict and !taken_s2 → 4, flush_s1=1
  5. is_jal_s1 or pred_taken_s1 → 2, flush_s1=0
  6. otherwise → 0
- An s2 redirect overrides any s1 prediction in the same cycle.
- BHT update, registered, on posedge when !rst & !stall & valid branch in s2:
  - idx_s2 = pc_s2[IDX_W+1:2].
  - Counter increments if taken, decrements if not taken.
  - Counter saturates at 2^CTR_BITS-1 and at 0; no wrap.
- Same-index lookup and update in one cycle: lookup returns the pre-update value; no bypass.
- Redirect latency: pc_sel and flush_s1 are valid in the same cycle the branch sits in s2; the BHT reflects the outcome from the next cycle.
- PC aliasing: upper PC bits are ignored; aliased entries share counters.
- stall: pc_sel and flush_s1 still drive; BHT and perf counters hold.

Optional Feature:
- Macro BRANCH_PERF_EN.
- Defined:
  - branch_count increments on every valid branch update.
  - mispredict_count increments when that branch mispredicts.
  - Both counters wrap modulo 2^CNT_W and clear on rst.
- Undefined: both outputs are constant 0 and no counter registers are synthesised.

Test Plan:
- Reset: assert rst 2 cycles → pc_sel=3, counters=0; after release, lookup of pc_s1=0x0000_0010 with is_branch_s1=1 → pred_taken_s1=0.
- Training: BEQ at pc_s2=0x0000_0010 (idx 4), breq=1, pred_taken_s2=0 for 2 cycles:
  - Cycle 1: pc_sel=1, flush_s1=1.
  - Afterwards: pc_s1=0x10 → pred_taken_s1=1.
  - Third taken resolution with pred_taken_s2=1 → pc_sel=0, no flush; counter saturates at 3.
- Recovery: BNE with breq=1, pred_taken_s2=1 → pc_sel=4, flush_s1=1; counter 3→2; mispredict_count +1 (BRANCH_PERF_EN).
- Priority: JALR in s2 with is_jal_s1=1 → pc_sel=1, flush_s1=1; no BHT change.
- Stall and hazards:
  - stall=1 with a taken BLT in s2 → pc_sel=1, BHT entry and counters unchanged.
  - Same-cycle lookup/update on idx 4 from 1→2 → pred_taken_s1=0 that cycle, 1 the next.
- Invalid func3 (010) with pred_taken_s2=1 → pc_sel=4, no BHT update, branch_count unchanged; with BRANCH_PERF_EN undefined, counters read 0 throughout.
